bj_kernel: RTL and testbench

- Blackjack dealer kernel.
- Requests cards from a card source (BJsource) over a NextCard/NewCard handshake.
- Accumulates the hand total with soft-ace handling, and declares a stand (OK) or a bust (Fail).
- Sits beside the card source in the CPU system; NewGame and Card come from the source, and NextCard goes back to it.

---
 rtl/bj_pkg.sv | 20 ++
 rtl/bj_card_value.sv | 19 +
 rtl/bj_kernel.sv | 120 ++++++++++++
 tb/tb_bj_kernel.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared types and constants for the blackjack dealer kernel.
package bj_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ADD    = 3'd2,
    CHECK  = 3'd3,
    WAITLO = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] ACE_CODE       = 4'd1;
  localparam logic [4:0] ACE_HIGH       = 5'd11;
  localparam logic [4:0] SOFT_ADJ       = 5'd10;
  localparam logic [4:0] FACE_MAX       = 5'd10;
  localparam int         STAND_MIN_DEF  = 17;
  localparam int         BUST_LIMIT_DEF = 21;

endpackage

// File: rtl/bj_card_value.sv
// Maps a 4-bit card code to its hard value; court codes 11..15 count as 10.
module bj_card_value
  import bj_pkg::*;
(
  input  logic [3:0] code,
  output logic [4:0] value,
  output logic       is_ace
);

  // Combinational code-to-value map; an ace reports its hard value of 1.
  always_comb begin
    value  = {1'b0, code};
    is_ace = (code == ACE_CODE);
    if ({1'b0, code} > FACE_MAX) begin
      value = FACE_MAX;
    end
  end

endmodule

// File: rtl/bj_kernel.sv
// Blackjack dealer kernel: requests cards, accumulates the hand with
// soft-ace handling, and flags a stand (OK) or a bust (Fail).
//
// state  | meaning
// IDLE   | after reset, outputs hold, waiting for NewGame
// REQ    | NextCard high, waiting for a valid card from the source
// ADD    | add the latched card value to Total
// CHECK  | demote a soft ace on overflow, or decide stand/bust/continue
// WAITLO | wait for NewCard to drop so one card is never counted twice
// DONE   | result held until NewGame
module bj_kernel
  import bj_pkg::*;
#(
  parameter int STAND_MIN  = STAND_MIN_DEF,
  parameter int BUST_LIMIT = BUST_LIMIT_DEF
) (
  input  logic       BJ_clock,
  input  logic       reset,
  input  logic       NewGame,
  input  logic       NewCard,
  input  logic [3:0] Card,
  output logic       NextCard,
  output logic       OK,
  output logic       Fail,
  output logic [4:0] Total,
  output logic       Ace
);

  localparam logic [4:0] STAND_TH = 5'(STAND_MIN);
  localparam logic [4:0] BUST_TH  = 5'(BUST_LIMIT);

  state_t     state;
  logic [4:0] card_val;
  logic       card_ace;
  logic [4:0] map_val;
  logic       map_ace;

  bj_card_value u_card_value (
    .code   (Card),
    .value  (map_val),
    .is_ace (map_ace)
  );

  // Single FSM with registered outputs; reset beats NewGame, NewGame beats all else.
  always_ff @(posedge BJ_clock) begin
    if (reset) begin
      state    <= IDLE;
      Total    <= '0;
      Ace      <= 1'b0;
      OK       <= 1'b0;
      Fail     <= 1'b0;
      NextCard <= 1'b0;
      card_val <= '0;
      card_ace <= 1'b0;
    end else if (NewGame) begin
      state    <= REQ;
      Total    <= '0;
      Ace      <= 1'b0;
      OK       <= 1'b0;
      Fail     <= 1'b0;
      NextCard <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          NextCard <= 1'b0;
        end
        REQ: begin
          if (NewCard && (Card != 4'd0)) begin
            card_val <= map_val;
            card_ace <= map_ace;
            state    <= ADD;
            NextCard <= 1'b0;
          end else begin
            NextCard <= 1'b1;
          end
        end
        ADD: begin
          // A first ace counts high; later aces (and all others) count hard.
          if (card_ace && !Ace) begin
            Total <= Total + ACE_HIGH;
            Ace   <= 1'b1;
          end else begin
            Total <= Total + card_val;
          end
          state <= CHECK;
        end
        CHECK: begin
          if (Total > BUST_TH) begin
            if (Ace) begin
              Total <= Total - SOFT_ADJ;
              Ace   <= 1'b0;
            end else begin
              Fail  <= 1'b1;
              state <= DONE;
            end
          end else if (Total >= STAND_TH) begin
            OK    <= 1'b1;
            state <= DONE;
          end else begin
            state <= WAITLO;
          end
        end
        WAITLO: begin
          if (!NewCard) begin
            state    <= REQ;
            NextCard <= 1'b1;
          end
        end
        DONE: begin
          NextCard <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          NextCard <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bj_kernel.sv
// Directed self-checking bench for the blackjack dealer kernel.
module tb_bj_kernel;
  import bj_pkg::*;

  logic       BJ_clock = 1'b0;
  logic       reset    = 1'b1;
  logic       NewGame  = 1'b0;
  logic       NewCard  = 1'b0;
  logic [3:0] Card     = 4'd0;
  logic       NextCard;
  logic       OK;
  logic       Fail;
  logic [4:0] Total;
  logic       Ace;

  int n_vec = 0;
  int n_err = 0;

  bj_kernel dut (
    .BJ_clock (BJ_clock),
    .reset    (reset),
    .NewGame  (NewGame),
    .NewCard  (NewCard),
    .Card     (Card),
    .NextCard (NextCard),
    .OK       (OK),
    .Fail     (Fail),
    .Total    (Total),
    .Ace      (Ace)
  );

  always #5 BJ_clock = ~BJ_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge BJ_clock);
  endtask

  task automatic new_game();
    NewGame = 1'b1;
    cyc(1);
    NewGame = 1'b0;
  endtask

  // Waits (bounded) for a request, presents the card for one cycle, returns
  // at the negedge right after the accepting edge.
  task automatic give_card(input logic [3:0] c);
    int k = 0;
    while (NextCard !== 1'b1 && k < 50) begin
      cyc(1);
      k++;
    end
    chk("nextcard_wait", 32'(NextCard), 32'd1);
    Card    = c;
    NewCard = 1'b1;
    cyc(1);
    NewCard = 1'b0;
  endtask

  initial begin
    // Reset for two cycles
    cyc(2);
    chk("rst_total", 32'(Total), 32'd0);
    chk("rst_ace", 32'(Ace), 32'd0);
    chk("rst_ok", 32'(OK), 32'd0);
    chk("rst_fail", 32'(Fail), 32'd0);
    chk("rst_nextcard", 32'(NextCard), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    Card = 4'd5; NewCard = 1'b1;
    cyc(2);
    NewCard = 1'b0;
    cyc(1);
    chk("idle_total", 32'(Total), 32'd0);
    chk("idle_state", 32'(dut.state), 32'(IDLE));
    chk("idle_nextcard", 32'(NextCard), 32'd0);

    // 10 + 7 = 17 stands
    new_game();
    chk("ng_nextcard", 32'(NextCard), 32'd1);
    chk("ng_state", 32'(dut.state), 32'(REQ));
    give_card(4'd10);
    chk("accept_nextcard_low", 32'(NextCard), 32'd0);
    cyc(1);
    chk("lat_total10", 32'(Total), 32'd10);
    give_card(4'd7);
    cyc(1);
    chk("lat_total17", 32'(Total), 32'd17);
    chk("lat_ok_not_yet", 32'(OK), 32'd0);
    cyc(1);
    chk("h17_ok", 32'(OK), 32'd1);
    chk("h17_fail", 32'(Fail), 32'd0);
    chk("h17_nextcard", 32'(NextCard), 32'd0);
    Card = 4'd3; NewCard = 1'b1;
    cyc(20);
    NewCard = 1'b0;
    chk("h17_hold_state", 32'(dut.state), 32'(DONE));
    chk("h17_hold_total", 32'(Total), 32'd17);
    chk("h17_hold_ok", 32'(OK), 32'd1);

    // 10 + 5 + 9 = 24 busts
    new_game();
    chk("ng_clears_ok", 32'(OK), 32'd0);
    chk("ng_clears_total", 32'(Total), 32'd0);
    give_card(4'd10);
    give_card(4'd5);
    give_card(4'd9);
    cyc(3);
    chk("h24_total", 32'(Total), 32'd24);
    chk("h24_fail", 32'(Fail), 32'd1);
    chk("h24_ok", 32'(OK), 32'd0);

    // Ace + 5 = soft 16; +10 demotes to 16 hard; +5 = 21 stands
    new_game();
    give_card(4'd1);
    give_card(4'd5);
    cyc(3);
    chk("s16_total", 32'(Total), 32'd16);
    chk("s16_ace", 32'(Ace), 32'd1);
    give_card(4'd10);
    cyc(1);
    chk("s26_total_pre", 32'(Total), 32'd26);
    chk("s26_ace_pre", 32'(Ace), 32'd1);
    cyc(1);
    chk("s26_demoted_total", 32'(Total), 32'd16);
    chk("s26_demoted_ace", 32'(Ace), 32'd0);
    chk("s26_no_fail", 32'(Fail), 32'd0);
    give_card(4'd5);
    cyc(3);
    chk("h21_total", 32'(Total), 32'd21);
    chk("h21_ok", 32'(OK), 32'd1);
    chk("h21_fail", 32'(Fail), 32'd0);

    // Ace, Ace, 13: 11 -> 12 soft -> 22 demoted to 12 hard; card 0 ignored
    new_game();
    give_card(4'd1);
    cyc(3);
    chk("aa_total11", 32'(Total), 32'd11);
    chk("aa_ace11", 32'(Ace), 32'd1);
    give_card(4'd1);
    cyc(3);
    chk("aa_total12", 32'(Total), 32'd12);
    chk("aa_ace12", 32'(Ace), 32'd1);
    Card = 4'd0; NewCard = 1'b1;
    cyc(3);
    NewCard = 1'b0;
    chk("card0_state", 32'(dut.state), 32'(REQ));
    chk("card0_total", 32'(Total), 32'd12);
    chk("card0_nextcard", 32'(NextCard), 32'd1);
    give_card(4'd13);
    cyc(4);
    chk("aa13_total", 32'(Total), 32'd12);
    chk("aa13_ace", 32'(Ace), 32'd0);
    chk("aa13_nextcard", 32'(NextCard), 32'd1);
    chk("aa13_ok", 32'(OK), 32'd0);

    // NewGame mid-hand at Total=12
    new_game();
    chk("mid_ng_total", 32'(Total), 32'd0);
    chk("mid_ng_ace", 32'(Ace), 32'd0);
    chk("mid_ng_nextcard", 32'(NextCard), 32'd1);

    // NewCard held for five cycles counts once
    Card = 4'd4; NewCard = 1'b1;
    cyc(5);
    NewCard = 1'b0;
    cyc(3);
    chk("held_total", 32'(Total), 32'd4);
    chk("held_nextcard", 32'(NextCard), 32'd1);

    // 10 + 6 + Ace reaches 27 before demotion, then stands at 17
    new_game();
    give_card(4'd10);
    give_card(4'd6);
    give_card(4'd1);
    cyc(1);
    chk("p27_total", 32'(Total), 32'd27);
    cyc(1);
    chk("p27_demoted", 32'(Total), 32'd17);
    chk("p27_ok_not_yet", 32'(OK), 32'd0);
    cyc(1);
    chk("p27_ok", 32'(OK), 32'd1);
    chk("p27_fail", 32'(Fail), 32'd0);

    // reset and NewGame together: reset wins
    new_game();
    give_card(4'd8);
    cyc(3);
    reset = 1'b1; NewGame = 1'b1;
    cyc(1);
    reset = 1'b0; NewGame = 1'b0;
    chk("rstng_state", 32'(dut.state), 32'(IDLE));
    chk("rstng_nextcard", 32'(NextCard), 32'd0);
    chk("rstng_total", 32'(Total), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
